// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory arbiter: load/store (DM) has priority over instruction fetch (IF),
// with a bounded DM streak so a pending fetch cannot starve. One access in flight at a time.
module unified_mem_arbiter #(
   parameter int unsigned DATA_WIDTH_POW  = 6,
   parameter int unsigned ADDR_WIDTH_POW  = 6,
   parameter int unsigned MEM_LATENCY     = 2,
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input  logic                             clk_in,
   input  logic                             rst,
   input  logic                             if_req_in,
   input  logic [(1<<ADDR_WIDTH_POW)-1:0]   if_addr_in,
   output logic                             if_gnt_out,
   output logic                             if_rvalid_out,
   output logic [31:0]                      if_rdata_out,
   input  logic                             dm_req_in,
   input  logic                             dm_we_in,
   input  logic [(1<<ADDR_WIDTH_POW)-1:0]   dm_addr_in,
   input  logic [(1<<DATA_WIDTH_POW)-1:0]   dm_wdata_in,
   output logic                             dm_gnt_out,
   output logic                             dm_rvalid_out,
   output logic [(1<<DATA_WIDTH_POW)-1:0]   dm_rdata_out,
   output logic                             mem_en_out,
   output logic                             mem_we_out,
   output logic [(1<<ADDR_WIDTH_POW)-1:0]   mem_addr_out,
   output logic [(1<<DATA_WIDTH_POW)-1:0]   mem_wdata_out,
   input  logic [(1<<DATA_WIDTH_POW)-1:0]   mem_rdata_in,
   output logic                             busy_out
);

   localparam int unsigned DW = 1 << DATA_WIDTH_POW;
   localparam int unsigned AW = 1 << ADDR_WIDTH_POW;
   localparam int unsigned LW = $clog2(MEM_LATENCY + 1);
   localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LATENCY);
   localparam logic [LW-1:0] LAT_LAST   = LW'(1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   logic [1:0]    state;
   logic          winner_dm;
   logic          cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [LW-1:0] lat_cnt;
   logic [SW-1:0] streak;
   logic [31:0]   if_rdata_r;
   logic [DW-1:0] dm_rdata_r;
   logic          sel_dm;

   // A pending fetch wins only once the DM streak has reached its limit
   always_comb begin
      sel_dm = dm_req_in && !(if_req_in && (streak == STREAK_MAX));
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state      <= IDLE;
         winner_dm  <= 1'b0;
         cmd_we     <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         lat_cnt    <= '0;
         if_rdata_r <= '0;
         dm_rdata_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (if_req_in || dm_req_in) begin
                  winner_dm <= sel_dm;
                  cmd_we    <= sel_dm && dm_we_in;
                  cmd_addr  <= sel_dm ? dm_addr_in : if_addr_in;
                  cmd_wdata <= sel_dm ? dm_wdata_in : '0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (cmd_we) begin
                  state <= IDLE;
               end else begin
                  lat_cnt <= LAT_INIT;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt - 1'b1;
               if (lat_cnt == LAT_LAST) begin
                  if (winner_dm) dm_rdata_r <= mem_rdata_in;
                  else           if_rdata_r <= mem_rdata_in[31:0];
                  state <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst || !if_req_in) begin
         streak <= '0;
      end else if (state == ISSUE) begin
         if (!winner_dm)                 streak <= '0;
         else if (streak != STREAK_MAX)  streak <= streak + 1'b1;
      end
   end

   assign mem_en_out    = (state == ISSUE);
   assign mem_we_out    = mem_en_out && cmd_we;
   assign mem_addr_out  = mem_en_out ? cmd_addr  : '0;
   assign mem_wdata_out = mem_en_out ? cmd_wdata : '0;
   assign if_gnt_out    = mem_en_out && !winner_dm;
   assign dm_gnt_out    = mem_en_out && winner_dm;
   assign if_rvalid_out = (state == RESP) && !winner_dm;
   assign dm_rvalid_out = (state == RESP) && winner_dm;
   assign if_rdata_out  = if_rdata_r;
   assign dm_rdata_out  = dm_rdata_r;
   assign busy_out      = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomised bench for unified_mem_arbiter: transaction-level schedule model plus a latency memory.
module tb_unified_mem_arbiter;

   localparam int unsigned LAT  = 2;
   localparam int unsigned MAXS = 2;
   localparam int unsigned NCYC = 4000;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic        if_req_in = 1'b0;
   logic [63:0] if_addr_in = '0;
   logic        if_gnt_out, if_rvalid_out;
   logic [31:0] if_rdata_out;
   logic        dm_req_in = 1'b0;
   logic        dm_we_in = 1'b0;
   logic [63:0] dm_addr_in = '0;
   logic [63:0] dm_wdata_in = '0;
   logic        dm_gnt_out, dm_rvalid_out;
   logic [63:0] dm_rdata_out;
   logic        mem_en_out, mem_we_out;
   logic [63:0] mem_addr_out, mem_wdata_out;
   logic [63:0] mem_rdata_in = '0;
   logic        busy_out;

   always #5 clk_in = ~clk_in;

   unified_mem_arbiter #(
      .DATA_WIDTH_POW (6),
      .ADDR_WIDTH_POW (6),
      .MEM_LATENCY    (LAT),
      .MAX_DATA_STREAK(MAXS)
   ) dut (
      .clk_in(clk_in), .rst(rst),
      .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_gnt_out(if_gnt_out),
      .if_rvalid_out(if_rvalid_out), .if_rdata_out(if_rdata_out),
      .dm_req_in(dm_req_in), .dm_we_in(dm_we_in), .dm_addr_in(dm_addr_in),
      .dm_wdata_in(dm_wdata_in), .dm_gnt_out(dm_gnt_out), .dm_rvalid_out(dm_rvalid_out),
      .dm_rdata_out(dm_rdata_out), .mem_en_out(mem_en_out), .mem_we_out(mem_we_out),
      .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
      .mem_rdata_in(mem_rdata_in), .busy_out(busy_out)
   );

   typedef struct packed {
      logic        vld;
      logic        is_dm;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic        is_dm;
      logic [63:0] data;
   } rsp_t;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int          cyc = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [63:0] mem_init(input logic [63:0] a);
      return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0] + 32'h1357_9BDF};
   endfunction

   // Reference model: each arbitration decision schedules its command and response cycles
   cmd_t        cmd_sched[int];
   rsp_t        rsp_sched[int];
   logic [63:0] mdl_mem[logic [63:0]];
   logic [63:0] rsp_mem[logic [63:0]];
   logic [63:0] rd_due[int];
   int          free_at = 0;
   int unsigned streak  = 0;
   logic [31:0] exp_if_rdata = '0;
   logic [63:0] exp_dm_rdata = '0;
   logic        saw_if_gnt = 1'b0;
   logic        saw_dm_gnt = 1'b0;

   initial begin
      cmd_t ecmd, ncmd;
      rsp_t ersp, nrsp;
      logic e_if_rv, e_dm_rv, take_if;
      logic [63:0] rd;
      for (int c = 0; c < int'(NCYC); c++) begin
         @(posedge clk_in);
         #1;
         cyc = c;
         rst = (c < 3) || ($urandom_range(0, 59) == 0);
         mem_rdata_in = rd_due.exists(c) ? rd_due[c] : {$urandom, $urandom};

         if (if_req_in && saw_if_gnt) begin
            if_req_in = 1'b0;
         end else if (!if_req_in) begin
            if ($urandom_range(0, 3) != 0) begin
               if_req_in  = 1'b1;
               if_addr_in = 64'($urandom_range(0, 31)) << 2;
            end
         end else if ($urandom_range(0, 39) == 0) begin
            if_req_in = 1'b0;
         end

         if (dm_req_in && saw_dm_gnt) begin
            dm_req_in = 1'b0;
         end else if (!dm_req_in) begin
            if ($urandom_range(0, 9) < 7) begin
               dm_req_in   = 1'b1;
               dm_we_in    = $urandom_range(0, 1) == 1;
               dm_addr_in  = 64'($urandom_range(0, 15)) << 3;
               dm_wdata_in = {$urandom, $urandom};
            end
         end else if ($urandom_range(0, 39) == 0) begin
            dm_req_in = 1'b0;
         end

         @(negedge clk_in);
         ecmd    = cmd_sched.exists(c) ? cmd_sched[c] : '0;
         e_if_rv = 1'b0;
         e_dm_rv = 1'b0;
         if (rsp_sched.exists(c)) begin
            ersp = rsp_sched[c];
            if (ersp.is_dm) begin
               e_dm_rv      = 1'b1;
               exp_dm_rdata = ersp.data;
            end else begin
               e_if_rv      = 1'b1;
               exp_if_rdata = ersp.data[31:0];
            end
         end

         if (c >= 1) begin
            check("if_gnt",    64'(if_gnt_out),    64'(ecmd.vld && !ecmd.is_dm));
            check("dm_gnt",    64'(dm_gnt_out),    64'(ecmd.vld && ecmd.is_dm));
            check("mem_en",    64'(mem_en_out),    64'(ecmd.vld));
            check("mem_we",    64'(mem_we_out),    64'(ecmd.we));
            check("mem_addr",  mem_addr_out,       ecmd.addr);
            check("mem_wdata", mem_wdata_out,      ecmd.wdata);
            check("if_rvalid", 64'(if_rvalid_out), 64'(e_if_rv));
            check("dm_rvalid", 64'(dm_rvalid_out), 64'(e_dm_rv));
            check("if_rdata",  64'(if_rdata_out),  64'(exp_if_rdata));
            check("dm_rdata",  dm_rdata_out,       exp_dm_rdata);
            check("busy",      64'(busy_out),      64'(c < free_at));
         end
         saw_if_gnt = if_gnt_out;
         saw_dm_gnt = dm_gnt_out;

         if (mem_en_out) begin
            if (mem_we_out) rsp_mem[mem_addr_out] = mem_wdata_out;
            else rd_due[c + int'(LAT)] = rsp_mem.exists(mem_addr_out) ? rsp_mem[mem_addr_out]
                                                                      : mem_init(mem_addr_out);
         end

         if (rst) begin
            cmd_sched.delete();
            rsp_sched.delete();
            free_at      = c + 1;
            streak       = 0;
            exp_if_rdata = '0;
            exp_dm_rdata = '0;
         end else begin
            if (c >= free_at && (if_req_in || dm_req_in)) begin
               take_if     = if_req_in && (!dm_req_in || streak == MAXS);
               ncmd.vld    = 1'b1;
               ncmd.is_dm  = !take_if;
               ncmd.we     = !take_if && dm_we_in;
               ncmd.addr   = take_if ? if_addr_in : dm_addr_in;
               ncmd.wdata  = take_if ? 64'd0 : dm_wdata_in;
               cmd_sched[c + 1] = ncmd;
               if (ncmd.we) begin
                  mdl_mem[ncmd.addr] = ncmd.wdata;
                  free_at = c + 2;
               end else begin
                  rd = mdl_mem.exists(ncmd.addr) ? mdl_mem[ncmd.addr] : mem_init(ncmd.addr);
                  nrsp.is_dm = ncmd.is_dm;
                  nrsp.data  = rd;
                  rsp_sched[c + 2 + int'(LAT)] = nrsp;
                  free_at = c + 3 + int'(LAT);
               end
            end
            if (ecmd.vld && !ecmd.is_dm)            streak = 0;
            else if (!if_req_in)                    streak = 0;
            else if (ecmd.vld && streak < MAXS)     streak = streak + 1;
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
